ps2_rx_frame: RTL and testbench
===============================

Name: ps2_rx_frame

Overview:
- Receive front-end of the PS/2 controller: synchronises and glitch-filters raw ps2_clk/ps2_data, detects device-clock falling edges, and assembles 11-bit frames.
- Frame order on the wire: start, d0..d7, parity, stop. Frames are shifted MSB-first into an 11-bit register (new bit at [0]), so after 11 bits: [10]=start, [9:2]=d0..d7, [1]=parity, [0]=stop.
- Validates each frame and delivers one scan-code byte per frame to the downstream keyboard decoder.

Parameters:
- SYNC_STAGES, 2, flip-flop synchroniser depth on ps2_clk and ps2_data (min 2).
- FILTER_LEN, 4, consecutive identical synchronised ps2_clk samples required before the filtered clock changes.
- TIMEOUT_CYCLES, 50000, idle clk cycles between falling edges inside a frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
- ps2_data  input  1  raw PS/2 data pin, asynchronous.
- rx_en  input  1  receive enable; sampled only in IDLE.
- data_out  output  8  received byte, d7..d0; holds last good byte.
- data_valid  output  1  one-cycle strobe: data_out updated.
- parity_err  output  1  one-cycle strobe: odd-parity check failed.
- frame_err  output  1  one-cycle strobe: bad start/stop bit or timeout.
- busy  output  1  high while a frame is in progress (RECV or CHECK).

Behaviour:
- Reset: all outputs 0; state IDLE; bit count 0; shift register 0; filtered clock 1; timeout counter 0. Reset mid-frame discards the partial frame, and no strobe is issued.
- Filter: filtered clock takes the synchronised value after FILTER_LEN consecutive equal samples. fall_stb is a 1-cycle pulse when the filtered clock goes 1->0. Data is sampled from synchronised ps2_data in the fall_stb cycle.
- IDLE: on fall_stb with rx_en=1, shift in bit, count=1, go to RECV. With rx_en=0, edges are ignored.
- RECV: each fall_stb shifts in one bit, increments count, and clears the timeout counter. When count reaches 11, go to CHECK next cycle. Timeout counter reaching TIMEOUT_CYCLES -> frame_err strobe, go to IDLE. rx_en has no effect once a frame has started.
- CHECK (one cycle): checks, in priority order:
  - start!=0 or stop!=1 -> frame_err.
  - else XOR(d0..d7, parity)!=1 -> parity_err.
  - else load data_out and assert data_valid.
  - Exactly one strobe per frame. The strobe is registered and rises the cycle after CHECK (2 cycles after the 11th fall_stb). Then IDLE.
- Pin-to-strobe latency for the 11th edge: SYNC_STAGES+FILTER_LEN+2 clk cycles.
- A fall_stb arriving in CHECK is not lost: it is treated as the start bit of the next frame.
- data_out changes only with data_valid.

Optional Feature:
- Macro: PS2_BREAK_DECODE_EN.
- With the macro:
  - Extra outputs is_break (1) and is_extended (1).
  - Good bytes 0xF0 and 0xE0 set sticky prefix flags and produce no data_valid.
  - The next good non-prefix byte asserts data_valid with is_break/is_extended reflecting the flags; flags clear in the same cycle.
  - Any error strobe also clears the flags.
- Without the macro: ports absent, every good byte is reported raw.

Decomposition:
- Package ps2_pkg: state enum (IDLE, RECV, CHECK), FRAME_BITS=11, bit-position constants (START_POS=10, DATA_MSB=9, DATA_LSB=2, PARITY_POS=1, STOP_POS=0), PS2_BREAK=8'hF0, PS2_EXT=8'hE0.
- Sub-module ps2_sync_filter: synchroniser, glitch filter and fall_stb generation; outputs fall_stb and data_sync.

Test Plan:
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1), ~60 us PS/2 period -> data_valid once, data_out=0x1C, no error strobes.
- Frame 0x1C with parity bit 1 -> parity_err single pulse, data_valid 0, data_out unchanged.
- 5 edges then silence -> frame_err exactly TIMEOUT_CYCLES cycles after the 5th fall_stb, busy drops. A following full 0x29 frame is received correctly.
- 2-cycle low glitch on ps2_clk mid-frame with FILTER_LEN=4 -> no extra bit counted, frame decodes correctly.
- reset asserted after 6 bits, then a full 0x5A frame -> no strobes during reset, data_valid with data_out=0x5A.
- PS2_BREAK_DECODE_EN defined: frames E0, F0, 0x75 -> a single data_valid, data_out=0x75, is_break=1, is_extended=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive front-end: FSM state encoding,
// frame geometry and the scan-code prefix bytes.
// Bit positions refer to the 11-bit frame after all bits have been shifted
// in (new bit enters at [0]).
package ps2_pkg;

  // State constants kept as plain localparams for legacy users, enum for RTL.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RECV  = ST_RECV,
    CHECK = ST_CHECK
  } ps2_state_e;

  localparam int FRAME_BITS = 11;
  localparam int START_POS  = 10;
  localparam int DATA_MSB   = 9;
  localparam int DATA_LSB   = 2;
  localparam int PARITY_POS = 1;
  localparam int STOP_POS   = 0;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // d0 arrives first, so it sits at DATA_MSB; reverse into d7..d0 order.
  function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] f);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[i] = f[DATA_MSB - i];
    end
    return b;
  endfunction

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic frame_parity_ok(input logic [FRAME_BITS-1:0] f);
    return ^f[DATA_MSB:PARITY_POS];
  endfunction

  // Start bit must be 0 and stop bit 1.
  function automatic logic frame_bounds_ok(input logic [FRAME_BITS-1:0] f);
    return (f[START_POS] == 1'b0) && (f[STOP_POS] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// PS/2 pin conditioning: multi-flop synchronisers on ps2_clk and ps2_data,
// a consecutive-sample glitch filter on the clock and a one-cycle strobe on
// each filtered falling edge.
// fall_stb rises in the same cycle the filtered clock first reads 0, i.e.
// SYNC_STAGES + FILTER_LEN clk edges after the pin falls.
module ps2_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_stb,
  output logic data_sync
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_filt;
  logic                   r_fall;

  logic w_clk_s;
  logic w_differs;
  logic w_settle;

  assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
  assign w_differs = (w_clk_s != r_filt);
  // The FILTER_LEN-th consecutive differing sample commits the new level.
  assign w_settle  = w_differs && (r_cnt == CNT_W'(FILTER_LEN - 1));

  // Synchronise both pins; the bus idles high so reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Count consecutive samples that disagree with the filtered clock; any
  // agreeing sample restarts the count so short glitches never commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_filt <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_fall <= w_settle && !w_clk_s;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_settle) begin
        r_cnt  <= '0;
        r_filt <= w_clk_s;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign fall_stb  = r_fall;
  assign data_sync = r_data_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 receive frame assembler. Shifts in start, d0..d7, parity and stop on
// each filtered device-clock falling edge, validates the frame in a one-cycle
// CHECK state and issues exactly one registered strobe per frame
// (data_valid, parity_err or frame_err). An inter-edge timeout aborts stalled
// frames.
// Optional build macro PS2_BREAK_DECODE_EN: absorbs 0xF0/0xE0 prefix bytes
// into sticky flags reported as is_break/is_extended with the next byte.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
`ifdef PS2_BREAK_DECODE_EN
  ,
  output logic       is_break,
  output logic       is_extended
`endif
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic w_fall;
  logic w_data;

  ps2_state_e             r_state;
  logic [3:0]             r_cnt;
  logic [FRAME_BITS-1:0]  r_shift;
  logic [TMO_W-1:0]       r_tmo;
  logic [7:0]             r_data;
  logic                   r_dv;
  logic                   r_pe;
  logic                   r_fe;

  logic [FRAME_BITS-1:0]  w_shift_next;
  logic [7:0]             w_byte;
  logic                   w_bounds_ok;
  logic                   w_parity_ok;
  logic                   w_last_bit;
  logic                   w_tmo_hit;

`ifdef PS2_BREAK_DECODE_EN
  logic r_brk_flag;
  logic r_ext_flag;
  logic r_is_break;
  logic r_is_ext;
`endif

  ps2_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sync_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .fall_stb  (w_fall),
    .data_sync (w_data)
  );

  assign w_shift_next = {r_shift[FRAME_BITS-2:0], w_data};
  assign w_byte       = frame_byte(r_shift);
  assign w_bounds_ok  = frame_bounds_ok(r_shift);
  assign w_parity_ok  = frame_parity_ok(r_shift);
  assign w_last_bit   = (r_cnt == 4'(FRAME_BITS - 1));
  assign w_tmo_hit    = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  // Frame FSM: bit collection, timeout, validation and strobe generation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_tmo   <= '0;
      r_data  <= '0;
      r_dv    <= 1'b0;
      r_pe    <= 1'b0;
      r_fe    <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
      r_brk_flag <= 1'b0;
      r_ext_flag <= 1'b0;
      r_is_break <= 1'b0;
      r_is_ext   <= 1'b0;
`endif
    end else begin
      r_dv <= 1'b0;
      r_pe <= 1'b0;
      r_fe <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tmo <= '0;
          if (w_fall && rx_en) begin
            r_shift <= w_shift_next;
            r_cnt   <= 4'd1;
            r_tmo   <= TMO_W'(1);
            r_state <= RECV;
          end
        end

        RECV: begin
          if (w_fall) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + 4'd1;
            // The strobe cycle itself is the first elapsed idle cycle.
            r_tmo   <= TMO_W'(1);
            if (w_last_bit) begin
              r_state <= CHECK;
            end
          end else if (w_tmo_hit) begin
            r_fe    <= 1'b1;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_state <= IDLE;
`ifdef PS2_BREAK_DECODE_EN
            r_brk_flag <= 1'b0;
            r_ext_flag <= 1'b0;
`endif
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        CHECK: begin
          if (!w_bounds_ok) begin
            r_fe <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
            r_brk_flag <= 1'b0;
            r_ext_flag <= 1'b0;
`endif
          end else if (!w_parity_ok) begin
            r_pe <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
            r_brk_flag <= 1'b0;
            r_ext_flag <= 1'b0;
`endif
          end else begin
`ifdef PS2_BREAK_DECODE_EN
            if (w_byte == PS2_BREAK) begin
              r_brk_flag <= 1'b1;
            end else if (w_byte == PS2_EXT) begin
              r_ext_flag <= 1'b1;
            end else begin
              r_data     <= w_byte;
              r_dv       <= 1'b1;
              r_is_break <= r_brk_flag;
              r_is_ext   <= r_ext_flag;
              r_brk_flag <= 1'b0;
              r_ext_flag <= 1'b0;
            end
`else
            r_data <= w_byte;
            r_dv   <= 1'b1;
`endif
          end
          // An edge landing during CHECK is the start bit of the next frame.
          if (w_fall) begin
            r_shift <= w_shift_next;
            r_cnt   <= 4'd1;
            r_tmo   <= TMO_W'(1);
            r_state <= RECV;
          end else begin
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_state <= IDLE;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_tmo   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_dv;
  assign parity_err = r_pe;
  assign frame_err  = r_fe;
  assign busy       = (r_state != IDLE);

`ifdef PS2_BREAK_DECODE_EN
  assign is_break    = r_is_break;
  assign is_extended = r_is_ext;
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: good frame with latency check, parity
// error, timeout, clock glitch, mid-frame reset, rx_en gating, bad stop bit
// and (with PS2_BREAK_DECODE_EN) prefix decoding.
module tb_ps2_rx_frame;

  localparam int TMO  = 200;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rx_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
`ifdef PS2_BREAK_DECODE_EN
  logic       is_break;
  logic       is_extended;
  logic       last_brk = 1'b0;
  logic       last_ext = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int dv_cnt = 0;
  int pe_cnt = 0;
  int fe_cnt = 0;
  int b_dv, b_pe, b_fe;

  ps2_rx_frame #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_en      (rx_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef PS2_BREAK_DECODE_EN
    ,
    .is_break    (is_break),
    .is_extended (is_extended)
`endif
  );

  always #5 clk = ~clk;

  // Count strobe-high cycles.
  always @(negedge clk) begin
    if (data_valid) dv_cnt++;
    if (parity_err) pe_cnt++;
    if (frame_err)  fe_cnt++;
`ifdef PS2_BREAK_DECODE_EN
    if (data_valid) begin
      last_brk = is_break;
      last_ext = is_extended;
    end
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  // Same as ps2_bit but with a 2-cycle low pulse during the high phase.
  task automatic ps2_bit_glitch(input logic b);
    ps2_data = b;
    tick(HALF / 2);
    ps2_clk = 1'b0;
    tick(2);
    ps2_clk = 1'b1;
    tick(HALF / 2 - 2);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] w, input int n);
    for (int i = 0; i < n; i++) ps2_bit(w[i]);
  endtask

  // Wire order: [0]=start, [8:1]=d7..d0 (d0 first), [9]=odd parity, [10]=stop.
  function automatic logic [10:0] mk(input logic [7:0] d, input logic flip_par, input logic stop);
    return {stop, (~^d) ^ flip_par, d, 1'b0};
  endfunction

  task automatic snap();
    b_dv = dv_cnt;
    b_pe = pe_cnt;
    b_fe = fe_cnt;
  endtask

  task automatic chk_counts(input string tag, input int edv, input int epe, input int efe);
    chk({tag, "_dv"}, dv_cnt - b_dv, edv);
    chk({tag, "_pe"}, pe_cnt - b_pe, epe);
    chk({tag, "_fe"}, fe_cnt - b_fe, efe);
  endtask

  initial begin
    logic [10:0] w;

    // Reset state
    reset = 1'b1; rx_en = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(5);
    chk("rst_data", data_out, 8'h00);
    chk("rst_dv", data_valid, 0);
    chk("rst_pe", parity_err, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick(5);

    // Frame 0x1C with pin-to-strobe latency on the 11th edge
    snap();
    w = mk(8'h1C, 1'b0, 1'b1);
    send_bits(w, 1);
    chk("busy_mid", busy, 1);
    for (int i = 1; i < 10; i++) ps2_bit(w[i]);
    ps2_data = w[10];
    tick(HALF);
    ps2_clk = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      if (i == 7) chk("lat_busy_check", busy, 1);
      if (i >= 7) chk($sformatf("lat_dv_%0d", i), data_valid, (i == 8) ? 1 : 0);
    end
    chk("lat_busy_after", busy, 0);
    tick(HALF - 9);
    ps2_clk = 1'b1;
    tick(10);
    chk("f1c_data", data_out, 8'h1C);
    chk_counts("f1c", 1, 0, 0);

    // Parity error on 0x1C
    snap();
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11);
    tick(10);
    chk_counts("par", 0, 1, 0);
    chk("par_data_hold", data_out, 8'h1C);

    // Timeout after 5 edges
    snap();
    w = mk(8'h29, 1'b0, 1'b1);
    send_bits(w, 4);
    ps2_data = w[4];
    tick(HALF);
    ps2_clk = 1'b0;
    for (int i = 1; i <= 207; i++) begin
      tick(1);
      if (i == HALF) ps2_clk = 1'b1;
      if (i == 205) begin
        chk("tmo_fe_205", frame_err, 0);
        chk("tmo_busy_205", busy, 1);
      end
      if (i == 206) begin
        chk("tmo_fe_206", frame_err, 1);
        chk("tmo_busy_206", busy, 0);
      end
      if (i == 207) chk("tmo_fe_207", frame_err, 0);
    end
    tick(10);
    chk_counts("tmo", 0, 0, 1);

    // Full 0x29 frame after the timeout
    snap();
    send_bits(mk(8'h29, 1'b0, 1'b1), 11);
    tick(10);
    chk("f29_data", data_out, 8'h29);
    chk_counts("f29", 1, 0, 0);

    // Clock glitch mid-frame
    snap();
    w = mk(8'h4B, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      if (i == 5) ps2_bit_glitch(w[i]);
      else        ps2_bit(w[i]);
    end
    tick(10);
    chk("glitch_data", data_out, 8'h4B);
    chk_counts("glitch", 1, 0, 0);

    // Reset after 6 bits
    snap();
    send_bits(mk(8'hFF, 1'b0, 1'b1), 6);
    tick(5);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    tick(3);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_data", data_out, 8'h00);
    reset = 1'b0;
    tick(20);
    chk_counts("rst_mid", 0, 0, 0);
    snap();
    send_bits(mk(8'h5A, 1'b0, 1'b1), 11);
    tick(10);
    chk("f5a_data", data_out, 8'h5A);
    chk_counts("f5a", 1, 0, 0);

    // rx_en low: edges ignored
    snap();
    rx_en = 1'b0;
    w = mk(8'h33, 1'b0, 1'b1);
    send_bits(w, 3);
    chk("rxoff_busy", busy, 0);
    for (int i = 3; i < 11; i++) ps2_bit(w[i]);
    tick(10);
    chk_counts("rxoff", 0, 0, 0);
    chk("rxoff_data", data_out, 8'h5A);
    rx_en = 1'b1;
    tick(5);

    // Bad stop bit
    snap();
    send_bits(mk(8'h12, 1'b0, 1'b0), 11);
    tick(10);
    chk_counts("stop", 0, 0, 1);
    chk("stop_data", data_out, 8'h5A);

`ifdef PS2_BREAK_DECODE_EN
    // E0 F0 75 -> one byte with both flags
    snap();
    send_bits(mk(8'hE0, 1'b0, 1'b1), 11);
    send_bits(mk(8'hF0, 1'b0, 1'b1), 11);
    tick(10);
    chk_counts("prefix", 0, 0, 0);
    send_bits(mk(8'h75, 1'b0, 1'b1), 11);
    tick(10);
    chk_counts("brk", 1, 0, 0);
    chk("brk_data", data_out, 8'h75);
    chk("brk_is_break", last_brk, 1);
    chk("brk_is_ext", last_ext, 1);
    // Flags cleared after use
    snap();
    send_bits(mk(8'h16, 1'b0, 1'b1), 11);
    tick(10);
    chk_counts("plain", 1, 0, 0);
    chk("plain_is_break", last_brk, 0);
    chk("plain_is_ext", last_ext, 0);
`else
    // Prefix bytes are reported raw
    snap();
    send_bits(mk(8'hF0, 1'b0, 1'b1), 11);
    tick(10);
    chk_counts("raw_f0", 1, 0, 0);
    chk("raw_f0_data", data_out, 8'hF0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
